// File: rtl/cronometro_param.sv
// cronometro_param: parametrised min:sec:centisecond stopwatch.
//
// Four active-low buttons (start/pause/stop/lap) are synchronised, debounced
// and turned into one-cycle events that drive an IDLE/RUN/PAUSED FSM. While
// running, a prescaler produces a centisecond tick every CLK_DIV clocks. Lap
// times go into a NUM_LAPS-deep circular buffer. The registered display shows
// either the live time or a stored lap, as an absolute split or as a delta
// from the previous lap.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start_n, pause_n,    active-low buttons, asynchronous to clk
//   stop_n, lap_n
//   mode                 0 = absolute split, 1 = lap-to-lap delta
//   show_lap             0 = live time, 1 = lap entry rd_idx
//   rd_idx               lap index, 0 = oldest stored entry
//   cent_seg/seg/minutes displayed time (registered)
//   running              FSM is in RUN (registered)
//   lap_count, lap_full  number of valid lap entries, buffer full
//   overflow             sticky, time saturated at MIN_MAX:59.99
module cronometro_param #(
    parameter int CLK_DIV      = 1,
    parameter int NUM_LAPS     = 8,
    parameter int MIN_W        = 7,
    parameter int MIN_MAX      = 99,
    parameter int DEBOUNCE_CYC = 4,
    parameter int WRAP         = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start_n,
    input  logic                          pause_n,
    input  logic                          stop_n,
    input  logic                          lap_n,
    input  logic                          mode,
    input  logic                          show_lap,
    input  logic [$clog2(NUM_LAPS)-1:0]   rd_idx,
    output logic [6:0]                    cent_seg,
    output logic [5:0]                    seg,
    output logic [MIN_W-1:0]              minutes,
    output logic                          running,
    output logic [$clog2(NUM_LAPS+1)-1:0] lap_count,
    output logic                          lap_full,
    output logic                          overflow
);

    localparam int IDX_W = $clog2(NUM_LAPS);
    localparam int CNT_W = $clog2(NUM_LAPS + 1);
    localparam int PS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int DB_W  = $clog2(DEBOUNCE_CYC + 1);

    typedef struct packed {
        logic [MIN_W-1:0] mn;
        logic [5:0]       sc;
        logic [6:0]       cs;
    } tm_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t           state, state_nx;
    logic [PS_W-1:0]  presc;
    tm_t              tm;
    tm_t              lap_mem [NUM_LAPS];
    tm_t              base;
    logic [IDX_W-1:0] wr_ptr, old_ptr;
    logic [CNT_W-1:0] lap_cnt;
    logic             ovf;

    logic [3:0]       btn_p0, btn_p1, deb, ev;
    logic [DB_W-1:0]  db_cnt [4];

    logic start_ev, pause_ev, stop_ev, lap_ev;
    logic tick, lap_store, full;

    tm_t disp_d, disp_p1;
    logic running_p1;

    // ---------------------------------------------------------------------
    // Helper functions
    // ---------------------------------------------------------------------
    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W-1:0] b);
        logic [IDX_W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= (IDX_W+1)'(NUM_LAPS))
            s = s - (IDX_W+1)'(NUM_LAPS);
        return s[IDX_W-1:0];
    endfunction

    function automatic logic tm_at_max(input tm_t t);
        return (t.mn == MIN_W'(MIN_MAX)) && (t.sc == 6'd59) && (t.cs == 7'd99);
    endfunction

    function automatic tm_t tm_inc(input tm_t t);
        tm_t r;
        r = t;
        if (t.cs == 7'd99) begin
            r.cs = 7'd0;
            if (t.sc == 6'd59) begin
                r.sc = 6'd0;
                r.mn = t.mn + 1'b1;
            end else begin
                r.sc = t.sc + 1'b1;
            end
        end else begin
            r.cs = t.cs + 1'b1;
        end
        return r;
    endfunction

    // Mixed-radix a - b with borrow; callers guarantee a >= b.
    function automatic tm_t tm_sub(input tm_t a, input tm_t b);
        logic signed [8:0]       dc;
        logic signed [7:0]       ds;
        logic signed [MIN_W+1:0] dm;
        logic signed [MIN_W+1:0] one_m;
        tm_t r;
        one_m = (MIN_W+2)'(1);
        dc = $signed({2'b00, a.cs}) - $signed({2'b00, b.cs});
        ds = $signed({2'b00, a.sc}) - $signed({2'b00, b.sc});
        dm = $signed({2'b00, a.mn}) - $signed({2'b00, b.mn});
        if (dc < 0) begin
            dc = dc + 9'sd100;
            ds = ds - 8'sd1;
        end
        if (ds < 0) begin
            ds = ds + 8'sd60;
            dm = dm - one_m;
        end
        r.cs = dc[6:0];
        r.sc = ds[5:0];
        r.mn = dm[MIN_W-1:0];
        return r;
    endfunction

    // ---------------------------------------------------------------------
    // Stage p0/p1: two-flop synchroniser, then debounce and event extraction
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_p0 <= '1;
            btn_p1 <= '1;
            deb    <= '1;
            ev     <= '0;
            for (int i = 0; i < 4; i++) db_cnt[i] <= '0;
        end else begin
            btn_p0 <= {lap_n, stop_n, pause_n, start_n};
            btn_p1 <= btn_p0;
            for (int i = 0; i < 4; i++) begin
                ev[i] <= 1'b0;
                if (btn_p1[i] != deb[i]) begin
                    if (db_cnt[i] == DB_W'(DEBOUNCE_CYC - 1)) begin
                        deb[i]    <= btn_p1[i];
                        db_cnt[i] <= '0;
                        ev[i]     <= ~btn_p1[i];
                    end else begin
                        db_cnt[i] <= db_cnt[i] + 1'b1;
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    assign start_ev = ev[0];
    assign pause_ev = ev[1];
    assign stop_ev  = ev[2];
    assign lap_ev   = ev[3];

    // ---------------------------------------------------------------------
    // Control FSM
    // ---------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (stop_ev) begin
            state_nx = IDLE;
        end else begin
            case (state)
                IDLE:    if (start_ev && !pause_ev) state_nx = RUN;
                RUN:     if (pause_ev)              state_nx = PAUSED;
                PAUSED:  if (start_ev && !pause_ev) state_nx = RUN;
                default:                            state_nx = IDLE;
            endcase
        end
    end

    // ---------------------------------------------------------------------
    // Timekeeping and lap buffer
    // ---------------------------------------------------------------------
    assign tick      = (state == RUN) && (presc == PS_W'(CLK_DIV - 1));
    assign full      = (lap_cnt == CNT_W'(NUM_LAPS));
    assign lap_store = lap_ev && !stop_ev && (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst || stop_ev) begin
            presc   <= '0;
            tm      <= '0;
            ovf     <= 1'b0;
            base    <= '0;
            wr_ptr  <= '0;
            old_ptr <= '0;
            lap_cnt <= '0;
            for (int i = 0; i < NUM_LAPS; i++) lap_mem[i] <= '0;
        end else begin
            if (state == RUN)
                presc <= tick ? '0 : presc + 1'b1;
            else if (state == IDLE)
                presc <= '0;

            if (tick) begin
                if (tm_at_max(tm)) ovf <= 1'b1;
                else               tm  <= tm_inc(tm);
            end

            // The stored value is the pre-tick time because of NBA ordering.
            if (lap_store) begin
                if (!full) begin
                    lap_mem[wr_ptr] <= tm;
                    wr_ptr          <= idx_add(wr_ptr, IDX_W'(1));
                    lap_cnt         <= lap_cnt + 1'b1;
                end else if (WRAP != 0) begin
                    // When full, wr_ptr points at the oldest entry.
                    base            <= lap_mem[wr_ptr];
                    lap_mem[wr_ptr] <= tm;
                    wr_ptr          <= idx_add(wr_ptr, IDX_W'(1));
                    old_ptr         <= idx_add(old_ptr, IDX_W'(1));
                end
            end
        end
    end

    // ---------------------------------------------------------------------
    // Stage p1: registered display selection
    // ---------------------------------------------------------------------
    always_comb begin
        tm_t cur, prv;
        disp_d = tm;
        cur    = lap_mem[idx_add(old_ptr, rd_idx)];
        prv    = base;
        if (rd_idx != '0)
            prv = lap_mem[idx_add(old_ptr, rd_idx - 1'b1)];
        if (show_lap) begin
            if (CNT_W'(rd_idx) >= lap_cnt) disp_d = '0;
            else if (!mode)                disp_d = cur;
            else                           disp_d = tm_sub(cur, prv);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp_p1    <= '0;
            running_p1 <= 1'b0;
        end else begin
            disp_p1    <= disp_d;
            running_p1 <= (state == RUN);
        end
    end

    assign cent_seg  = disp_p1.cs;
    assign seg       = disp_p1.sc;
    assign minutes   = disp_p1.mn;
    assign running   = running_p1;
    assign lap_count = lap_cnt;
    assign lap_full  = full;
    assign overflow  = ovf;

endmodule

// File: doc/cronometro_param.md
Name: cronometro_param

Overview:
- Parametrised stopwatch (min:sec:centisecond) with a start/pause/stop control FSM and debounced active-low buttons.
- Laps are stored in a NUM_LAPS-deep buffer. A selectable display shows either absolute split times or lap-to-lap deltas.
- Successor to the fixed 3-lap, 100 Hz-only stopwatch; it drives the board display/readout logic.

Parameters:
- CLK_DIV, 1, clk cycles per centisecond tick (1 = 100 Hz clk; must be >= 1).
- NUM_LAPS, 8, lap buffer depth (2..16).
- MIN_W, 7, minutes field width.
- MIN_MAX, 99, maximum minutes value (< 2**MIN_W).
- DEBOUNCE_CYC, 4, consecutive stable cycles required to accept a button level change.
- WRAP, 0, lap buffer policy when full: 0 = drop new laps; 1 = overwrite oldest.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- start_n, in, 1, start/continue button, active low, asynchronous to clk.
- pause_n, in, 1, pause button, active low.
- stop_n, in, 1, stop/clear button, active low.
- lap_n, in, 1, lap store button, active low.
- mode, in, 1, 0 = display absolute split; 1 = display lap delta.
- show_lap, in, 1, 0 = live time; 1 = lap entry rd_idx.
- rd_idx, in, $clog2(NUM_LAPS), lap index; 0 = oldest stored.
- cent_seg, out, 7, displayed centiseconds 0..99.
- seg, out, 6, displayed seconds 0..59.
- minutes, out, MIN_W, displayed minutes 0..MIN_MAX.
- running, out, 1, FSM in RUN.
- lap_count, out, $clog2(NUM_LAPS+1), valid entries (saturates at NUM_LAPS).
- lap_full, out, 1, lap_count == NUM_LAPS.
- overflow, out, 1, sticky; time saturated.

Behaviour:
- Reset (rst=1 at posedge clk):
  - FSM goes to IDLE; time, prescaler, lap buffer, write pointer, base register, lap_count all 0.
  - All outputs 0.
  - Debounced button levels initialise to 1 (released).
- Buttons:
  - Each input passes a 2-FF synchroniser.
  - The debounced level changes only after the synchronised value differs from it for DEBOUNCE_CYC consecutive cycles.
  - The debounced 1->0 transition produces a one-cycle event (start_ev, pause_ev, stop_ev, lap_ev). Holding a button gives one event only.
- Priority in the same cycle: stop_ev > pause_ev > start_ev; lap_ev is independent but is ignored when stop_ev is present.
- FSM:
  - IDLE --start_ev--> RUN.
  - RUN --pause_ev--> PAUSED.
  - PAUSED --start_ev--> RUN.
  - Any state --stop_ev--> IDLE, clearing time, prescaler, overflow, lap buffer, lap_count and base.
  - start_ev in RUN, and pause_ev in IDLE/PAUSED, have no effect.
- Prescaler:
  - Counts 0..CLK_DIV-1 only in RUN.
  - tick = (RUN && prescaler == CLK_DIV-1).
  - Holds its value in PAUSED; cleared in IDLE.
  - First tick occurs CLK_DIV cycles after entering RUN.
- Time update on tick:
  - cent 99->0 carries into sec; sec 59->0 carries into min.
  - At MIN_MAX:59.99 the time holds (saturates) and overflow is set. overflow clears only on stop_ev or rst.
- Lap store (lap_ev in RUN or PAUSED; ignored in IDLE):
  - Stores current time register value as it is before any same-cycle tick increment.
  - Written at write pointer; pointer wraps modulo NUM_LAPS.
  - Full and WRAP=0: lap dropped; buffer and lap_count unchanged.
  - Full and WRAP=1: oldest entry overwritten; its value is copied to base; the oldest index advances.
- Display, registered (1-cycle latency from state/inputs):
  - show_lap=0: live time.
  - show_lap=1 and rd_idx >= lap_count: 0:00.00.
  - mode=0: entry[rd_idx] absolute.
  - mode=1: entry[rd_idx] − entry[rd_idx−1]; for rd_idx=0, entry[0] − base.
  - Delta subtraction is mixed-radix with borrow (cent mod 100, sec mod 60). Result is always >= 0 because entries are monotonic.
- running = (state == RUN), registered. lap_full and lap_count update the cycle after the store.

Test Plan (CLK_DIV=1, DEBOUNCE_CYC=2, NUM_LAPS=4, MIN_MAX=99 unless noted):
- Start pulse, run 6000 ticks -> live display 1:00.00, running=1; glitch on start_n shorter than 2 cycles produces no event.
- Start, run 150 ticks, pause 50 cycles, start again, run 50 ticks -> 0:02.00; during the pause the display holds 0:01.50, running=0.
- Laps at 0:01.00, 0:02.50, 0:04.00, mode=1 -> rd_idx 0,1,2 show 0:01.00, 0:01.50, 0:01.50; rd_idx=3 shows 0:00.00; lap_count=3.
- WRAP=0: 5 laps at 1 s intervals -> lap_count=4, lap_full=1, rd_idx 3 (mode=0) shows 0:04.00. WRAP=1: rd_idx 0 shows 0:02.00 and its mode=1 delta is 0:01.00.
- Preload/run to 99:59.99, then 10 more ticks -> display holds 99:59.99, overflow=1; stop -> all zero, overflow=0, lap_count=0.
- stop_ev and lap_ev in the same cycle -> no lap stored, time cleared. rst asserted mid-RUN -> next cycle all outputs 0, state IDLE.
